// File: rtl/difftest_v0_wb_collector.sv
// V0 writeback collector: merges partial 64-bit-half writebacks against a
// shadow copy of the V0 register file and queues full 128-bit values for the
// difftest sink, emitting at most one event per cycle.
module difftest_v0_wb_collector #(
  parameter int NUM_PORTS = 2,
  parameter int DEPTH     = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [NUM_PORTS-1:0]     io_wb_valid,
  input  logic [NUM_PORTS*5-1:0]   io_wb_addr,
  input  logic [NUM_PORTS*2-1:0]   io_wb_mask,
  input  logic [NUM_PORTS*128-1:0] io_wb_data,
  input  logic [7:0]               io_coreid,
  output logic                     io_out_enable,
  output logic                     io_out_valid,
  output logic [4:0]               io_out_address,
  output logic [63:0]              io_out_data_0,
  output logic [63:0]              io_out_data_1,
  output logic [7:0]               io_out_coreid,
  output logic                     io_stall,
  output logic                     io_overflow
);

  localparam int PW      = $clog2(DEPTH);
  localparam int CW      = PW + 1;
  localparam int ENTRY_W = 8 + 5 + 128;

  typedef logic [CW-1:0]      cnt_t;
  typedef logic [ENTRY_W-1:0] entry_t;

  localparam cnt_t DEPTH_C  = cnt_t'(DEPTH);
  localparam cnt_t NPORTS_C = cnt_t'(NUM_PORTS);
  localparam cnt_t ONE_C    = cnt_t'(1);

  // Overlay the enabled 64-bit halves of a write onto the previous value.
  function automatic logic [127:0] merge_half(input logic [127:0] old_val,
                                              input logic [127:0] new_val,
                                              input logic [1:0]   mask);
    logic [127:0] res;
    res[63:0]   = mask[0] ? new_val[63:0]   : old_val[63:0];
    res[127:64] = mask[1] ? new_val[127:64] : old_val[127:64];
    return res;
  endfunction

  function automatic entry_t pack_entry(input logic [7:0]   cid,
                                        input logic [4:0]   addr,
                                        input logic [127:0] data);
    return {cid, addr, data};
  endfunction

  logic [127:0] shadow [32];
  entry_t       fifo   [DEPTH];
  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;
  cnt_t          count;
  logic          overflow;

  logic          vld_p1;
  logic [4:0]    addr_p1;
  logic [127:0]  data_p1;
  logic [7:0]    coreid_p1;

  logic [4:0]   port_addr [NUM_PORTS];
  logic [1:0]   port_mask [NUM_PORTS];
  logic [127:0] port_data [NUM_PORTS];
  logic         eff       [NUM_PORTS];
  logic [127:0] merged    [NUM_PORTS];
  logic         accept    [NUM_PORTS];
  cnt_t         slot      [NUM_PORTS];

  logic   pop_fifo;
  logic   bypass;
  logic   drop;
  cnt_t   free_ent;
  cnt_t   n_acc;
  entry_t byp_entry;

  // Slice ports and merge each one against the shadow, letting a later port
  // see an earlier same-address port's result from this cycle.
  always_comb begin
    logic [127:0] base;
    base = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      port_addr[k] = io_wb_addr[k*5 +: 5];
      port_mask[k] = io_wb_mask[k*2 +: 2];
      port_data[k] = io_wb_data[k*128 +: 128];
      eff[k]       = io_wb_valid[k] && (port_mask[k] != 2'b00);
      merged[k]    = '0;
    end
    for (int k = 0; k < NUM_PORTS; k++) begin
      base = shadow[port_addr[k]];
      for (int j = 0; j < NUM_PORTS; j++) begin
        if (j < k && eff[j] && (port_addr[j] == port_addr[k])) begin
          base = merged[j];
        end
      end
      merged[k] = merge_half(base, port_data[k], port_mask[k]);
    end
  end

  // Accept effective events in port order up to the free entries (counting
  // this cycle's pop); when the queue is empty the first accepted event goes
  // straight into the output register.
  always_comb begin
    pop_fifo  = (count != '0);
    free_ent  = DEPTH_C - count + cnt_t'(pop_fifo);
    n_acc     = '0;
    drop      = 1'b0;
    byp_entry = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      accept[k] = 1'b0;
      slot[k]   = '0;
      if (eff[k]) begin
        if (n_acc < free_ent) begin
          accept[k] = 1'b1;
          slot[k]   = n_acc;
          if (n_acc == '0) begin
            byp_entry = pack_entry(io_coreid, port_addr[k], merged[k]);
          end
          n_acc = n_acc + ONE_C;
        end else begin
          drop = 1'b1;
        end
      end
    end
    bypass = !pop_fifo && (n_acc != '0);
  end

  // Shadow register file: every effective write commits, dropped or not.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) begin
        shadow[i] <= '0;
      end
    end else begin
      for (int k = 0; k < NUM_PORTS; k++) begin
        if (eff[k]) begin
          shadow[port_addr[k]] <= merged[k];
        end
      end
    end
  end

  // Event storage; stale contents are unreachable once the pointers reset.
  always_ff @(posedge clock) begin
    for (int k = 0; k < NUM_PORTS; k++) begin
      if (!reset && accept[k] && !(bypass && slot[k] == '0)) begin
        fifo[wptr + PW'(slot[k] - cnt_t'(bypass))] <=
          pack_entry(io_coreid, port_addr[k], merged[k]);
      end
    end
  end

  // Queue control, sticky overflow and the output register (stage p1).
  always_ff @(posedge clock) begin
    if (reset) begin
      wptr      <= '0;
      rptr      <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      vld_p1    <= 1'b0;
      addr_p1   <= '0;
      data_p1   <= '0;
      coreid_p1 <= '0;
    end else begin
      wptr  <= wptr + PW'(n_acc - cnt_t'(bypass));
      rptr  <= rptr + PW'(pop_fifo);
      count <= count + n_acc - cnt_t'(pop_fifo) - cnt_t'(bypass);
      if (drop) begin
        overflow <= 1'b1;
      end
      if (pop_fifo) begin
        vld_p1                         <= 1'b1;
        {coreid_p1, addr_p1, data_p1}  <= fifo[rptr];
      end else if (bypass) begin
        vld_p1                         <= 1'b1;
        {coreid_p1, addr_p1, data_p1}  <= byp_entry;
      end else begin
        vld_p1 <= 1'b0;
      end
    end
  end

  assign io_out_enable  = vld_p1;
  assign io_out_valid   = vld_p1;
  assign io_out_address = addr_p1;
  assign io_out_data_0  = data_p1[63:0];
  assign io_out_data_1  = data_p1[127:64];
  assign io_out_coreid  = coreid_p1;
  assign io_stall       = (DEPTH_C - count) < NPORTS_C;
  assign io_overflow    = overflow;

endmodule

// File: tb/tb_difftest_v0_wb_collector.sv
// Table-driven bench for the V0 writeback collector (NUM_PORTS=2, DEPTH=8).
module tb_difftest_v0_wb_collector;

  localparam logic [7:0] CID = 8'h5A;

  logic         clock = 1'b0;
  logic         reset;
  logic [1:0]   io_wb_valid;
  logic [9:0]   io_wb_addr;
  logic [3:0]   io_wb_mask;
  logic [255:0] io_wb_data;
  logic [7:0]   io_coreid;
  logic         io_out_enable;
  logic         io_out_valid;
  logic [4:0]   io_out_address;
  logic [63:0]  io_out_data_0;
  logic [63:0]  io_out_data_1;
  logic [7:0]   io_out_coreid;
  logic         io_stall;
  logic         io_overflow;

  difftest_v0_wb_collector #(.NUM_PORTS(2), .DEPTH(8)) dut (
    .clock          (clock),
    .reset          (reset),
    .io_wb_valid    (io_wb_valid),
    .io_wb_addr     (io_wb_addr),
    .io_wb_mask     (io_wb_mask),
    .io_wb_data     (io_wb_data),
    .io_coreid      (io_coreid),
    .io_out_enable  (io_out_enable),
    .io_out_valid   (io_out_valid),
    .io_out_address (io_out_address),
    .io_out_data_0  (io_out_data_0),
    .io_out_data_1  (io_out_data_1),
    .io_out_coreid  (io_out_coreid),
    .io_stall       (io_stall),
    .io_overflow    (io_overflow)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic         rst;
    logic [1:0]   v;
    logic [4:0]   a0, a1;
    logic [1:0]   m0, m1;
    logic [127:0] d0, d1;
    logic         ev;
    logic [4:0]   ea;
    logic [127:0] ed;
    logic [7:0]   ec;
    logic         es;
    logic         eo;
  } vec_t;

  vec_t vecs[$];
  int   applied = 0;
  int   miscompares = 0;

  // expected output-register contents, which hold while valid is low
  logic [4:0]   lst_a = '0;
  logic [127:0] lst_d = '0;
  logic [7:0]   lst_c = '0;

  task automatic add(input logic rst, input logic [1:0] v,
                     input logic [4:0] a0, input logic [1:0] m0, input logic [127:0] d0,
                     input logic [4:0] a1, input logic [1:0] m1, input logic [127:0] d1,
                     input logic ev, input logic [4:0] ea, input logic [127:0] ed,
                     input logic es, input logic eo);
    vec_t r;
    if (rst) begin
      lst_a = '0; lst_d = '0; lst_c = '0;
    end else if (ev) begin
      lst_a = ea; lst_d = ed; lst_c = CID;
    end
    r.rst = rst; r.v = v; r.a0 = a0; r.m0 = m0; r.d0 = d0;
    r.a1 = a1; r.m1 = m1; r.d1 = d1;
    r.ev = ev && !rst; r.ea = lst_a; r.ed = lst_d; r.ec = lst_c;
    r.es = es; r.eo = eo;
    vecs.push_back(r);
  endtask

  task automatic idle(input logic es, input logic eo);
    add(1'b0, 2'b00, 5'd0, 2'b00, '0, 5'd0, 2'b00, '0, 1'b0, 5'd0, '0, es, eo);
  endtask

  task automatic check(input string nm, input int row,
                       input logic [127:0] act, input logic [127:0] exp);
    if (act !== exp) begin
      $display("FAIL row %0d %s: got %h expected %h", row, nm, act, exp);
      miscompares++;
    end
  endtask

  function automatic logic [127:0] p0d(input int i);
    return {64'(i), 64'(256 + i)};
  endfunction
  function automatic logic [127:0] p1d(input int i);
    return {64'(512 + i), 64'(768 + i)};
  endfunction
  function automatic logic [127:0] q0d(input int i);
    return {64'(32'h400 + i), 64'(32'h500 + i)};
  endfunction
  function automatic logic [127:0] q1d(input int i);
    return {64'(32'h600 + i), 64'(32'h700 + i)};
  endfunction

  initial begin
    reset = 1'b1; io_wb_valid = '0; io_wb_addr = '0; io_wb_mask = '0;
    io_wb_data = '0; io_coreid = CID;

    // reset state
    add(1'b1, 2'b00, 5'd0, 2'b00, '0, 5'd0, 2'b00, '0, 1'b0, 5'd0, '0, 1'b0, 1'b0);
    idle(1'b0, 1'b0);
    // full write, then a bubble
    add(1'b0, 2'b01, 5'd3, 2'b11, {64'h1111111111111111, 64'h2222222222222222},
        5'd0, 2'b00, '0,
        1'b1, 5'd3, {64'h1111111111111111, 64'h2222222222222222}, 1'b0, 1'b0);
    idle(1'b0, 1'b0);
    // partial merge against an earlier full write
    add(1'b0, 2'b01, 5'd5, 2'b11, {64'hAAAAAAAAAAAAAAAA, 64'hBBBBBBBBBBBBBBBB},
        5'd0, 2'b00, '0,
        1'b1, 5'd5, {64'hAAAAAAAAAAAAAAAA, 64'hBBBBBBBBBBBBBBBB}, 1'b0, 1'b0);
    add(1'b0, 2'b01, 5'd5, 2'b01, {64'hFFFF0000FFFF0000, 64'hCCCCCCCCCCCCCCCC},
        5'd0, 2'b00, '0,
        1'b1, 5'd5, {64'hAAAAAAAAAAAAAAAA, 64'hCCCCCCCCCCCCCCCC}, 1'b0, 1'b0);
    idle(1'b0, 1'b0);
    // same cycle, same address, complementary halves
    add(1'b0, 2'b11, 5'd7, 2'b01, {64'hDEADDEADDEADDEAD, 64'd1},
        5'd7, 2'b10, {64'd2, 64'hBEEFBEEFBEEFBEEF},
        1'b1, 5'd7, {64'd0, 64'd1}, 1'b0, 1'b0);
    add(1'b0, 2'b00, 5'd0, 2'b00, '0, 5'd0, 2'b00, '0,
        1'b1, 5'd7, {64'd2, 64'd1}, 1'b0, 1'b0);
    idle(1'b0, 1'b0);
    // mask 00 with valid: no event, shadow untouched (checked by the next merge)
    add(1'b0, 2'b01, 5'd3, 2'b00, {128{1'b1}}, 5'd0, 2'b00, '0,
        1'b0, 5'd0, '0, 1'b0, 1'b0);
    add(1'b0, 2'b01, 5'd3, 2'b01, {64'hEEEEEEEEEEEEEEEE, 64'h33},
        5'd0, 2'b00, '0,
        1'b1, 5'd3, {64'h1111111111111111, 64'h33}, 1'b0, 1'b0);
    idle(1'b0, 1'b0);

    // fill to full and overflow: 10 double-write cycles, then drain
    for (int j = 0; j < 19; j++) begin
      int cyc, prt, cnt;
      logic [127:0] e;
      if (j < 16) begin cyc = j / 2; prt = j % 2; end
      else begin cyc = j - 8; prt = 0; end
      e   = (prt == 0) ? p0d(cyc) : p1d(cyc);
      cnt = (j <= 7) ? j + 1 : ((j <= 9) ? 8 : 17 - j);
      add(1'b0, (j <= 9) ? 2'b11 : 2'b00, 5'(j), 2'b11, p0d(j),
          5'(j + 16), 2'b11, p1d(j),
          j <= 17, (prt == 0) ? 5'(cyc) : 5'(cyc + 16), e, cnt >= 7, j >= 8);
    end
    // the dropped write to address 24 still landed in the shadow
    add(1'b0, 2'b01, 5'd24, 2'b01, {64'hFFFFFFFFFFFFFFFF, 64'h77},
        5'd0, 2'b00, '0,
        1'b1, 5'd24, {64'd520, 64'h77}, 1'b0, 1'b1);

    // queue 5 entries, then reset mid-stream
    for (int i = 0; i < 5; i++) begin
      logic [127:0] e;
      logic [4:0]   ea;
      e  = (i % 2 == 0) ? q0d(i / 2) : q1d(i / 2);
      ea = (i % 2 == 0) ? 5'(10 + i / 2) : 5'(20 + i / 2);
      add(1'b0, 2'b11, 5'(10 + i), 2'b11, q0d(i), 5'(20 + i), 2'b11, q1d(i),
          1'b1, ea, e, 1'b0, 1'b1);
    end
    add(1'b1, 2'b01, 5'd9, 2'b11, {128{1'b1}}, 5'd0, 2'b00, '0,
        1'b0, 5'd0, '0, 1'b0, 1'b0);
    idle(1'b0, 1'b0);
    idle(1'b0, 1'b0);
    idle(1'b0, 1'b0);
    // shadow was cleared; the write during reset was ignored
    add(1'b0, 2'b01, 5'd3, 2'b01, {64'h9999999999999999, 64'h44},
        5'd0, 2'b00, '0,
        1'b1, 5'd3, {64'd0, 64'h44}, 1'b0, 1'b0);
    add(1'b0, 2'b01, 5'd9, 2'b10, {64'h55, 64'h8888888888888888},
        5'd0, 2'b00, '0,
        1'b1, 5'd9, {64'h55, 64'd0}, 1'b0, 1'b0);
    idle(1'b0, 1'b0);

    // apply and compare
    for (int r = 0; r < vecs.size(); r++) begin
      reset       = vecs[r].rst;
      io_wb_valid = vecs[r].v;
      io_wb_addr  = {vecs[r].a1, vecs[r].a0};
      io_wb_mask  = {vecs[r].m1, vecs[r].m0};
      io_wb_data  = {vecs[r].d1, vecs[r].d0};
      @(posedge clock);
      #1;
      applied++;
      check("valid",    r, 128'(io_out_valid),   128'(vecs[r].ev));
      check("enable",   r, 128'(io_out_enable),  128'(vecs[r].ev));
      check("address",  r, 128'(io_out_address), 128'(vecs[r].ea));
      check("data_0",   r, 128'(io_out_data_0),  128'(vecs[r].ed[63:0]));
      check("data_1",   r, 128'(io_out_data_1),  128'(vecs[r].ed[127:64]));
      check("coreid",   r, 128'(io_out_coreid),  128'(vecs[r].ec));
      check("stall",    r, 128'(io_stall),       128'(vecs[r].es));
      check("overflow", r, 128'(io_overflow),    128'(vecs[r].eo));
    end

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule

// File: doc/difftest_v0_wb_collector.md
# difftest_v0_wb_collector

Producer-side front end for the vector V0 writeback difftest channel. It captures V0 register writebacks from the core's vector writeback ports, merges partial 64-bit-half writes against a shadow copy of the V0 register file, and queues the resulting full 128-bit values. It emits at most one event per cycle on the `enable`/`valid`/`address`/`data_0`/`data_1`/`coreid` channel, which feeds the V0 writeback difftest sink. It sits between the vector writeback arbitration and the difftest sink in simulation builds.

## Interface
- `NUM_PORTS`, default 2: number of writeback ports; port 0 is oldest within a cycle.
- `DEPTH`, default 8: event FIFO depth; power of two, ≥ `NUM_PORTS`.

- `clock`  in  1  — sole clock.
- `reset`  in  1  — synchronous, active-high.
- `io_wb_valid`  in  NUM_PORTS  — per-port writeback valid.
- `io_wb_addr`  in  NUM_PORTS*5  — per-port V0 register index, 5 bits each.
- `io_wb_mask`  in  NUM_PORTS*2  — per-port half-enable; bit0 writes data[63:0], bit1 writes data[127:64].
- `io_wb_data`  in  NUM_PORTS*128  — per-port write data.
- `io_coreid`  in  8  — core id, quasi-static.
- `io_out_enable`  out  1  — sink call enable; always equal to `io_out_valid`.
- `io_out_valid`  out  1  — event valid.
- `io_out_address`  out  5  — register index.
- `io_out_data_0`  out  64  — merged value [63:0].
- `io_out_data_1`  out  64  — merged value [127:64].
- `io_out_coreid`  out  8  — `io_coreid` registered with the event.
- `io_stall`  out  1  — free FIFO entries < NUM_PORTS, from the registered count.
- `io_overflow`  out  1  — sticky; set when any event is dropped.

## Operation
- Ports are processed in index order each cycle. A port is effective when valid=1 and mask≠0. A port with mask=00 is ignored: no event and no state change.
- Merge uses the 32×128 shadow, updated sequentially within the cycle. A later port targeting the same address as an earlier port sees that earlier port's update. Each effective port produces one event {addr, merged 128-bit value}.
- Shadow writes are committed for every effective port, including events dropped on overflow. Architectural shadow state is never lost.
- Push: effective events are enqueued in port order up to the free-entry count. This is evaluated with the same cycle's pop included: free = DEPTH − count + pop.
- Any excess events are dropped and set `io_overflow`. Only reset clears `io_overflow`.
- Pop: when the FIFO is non-empty, one entry is popped per cycle into the output register, and `io_out_valid`/`io_out_enable` are set to 1 for the next cycle. When the FIFO is empty, the output register loads valid=0. When valid=0, the data/address/coreid outputs hold their last values.
- Count: next = count + pushes − pop. Push and pop in the same cycle are allowed, including at full and at empty.
- FIFO pointers are log2(DEPTH) bits and wrap modulo DEPTH. Count is log2(DEPTH)+1 bits.
- Reset, including mid-operation:
  - count, pointers, shadow (all zero), `io_overflow` and all outputs are cleared to 0.
  - Writebacks presented during a reset cycle are ignored.
  - Queued entries are discarded and are never emitted.

## Timing
- Latency: a writeback in cycle t reaches the outputs no earlier than cycle t+1, because the FIFO is bypassed only through the output register. Port k of a burst emits at t+1+k when the queue is empty.
- Throughput: one event per cycle out. Up to NUM_PORTS events per cycle in.
- `io_stall` is combinational from the registered count only; it has no path from the inputs. Upstream is expected to honour it; the collector does not backpressure otherwise.
- `io_overflow` rises in the cycle after the drop.
- All outputs are 0 in the cycle after reset is asserted and remain 0 until the first post-reset pop.

## Test plan
- Full write: port0 addr 3, mask 11, data hi=0x1111111111111111, lo=0x2222222222222222 → next cycle valid=enable=1, addr 3, data_0=0x2222…, data_1=0x1111…; the following cycle valid=0.
- Partial merge: addr 5 full {hi=0xA…A, lo=0xB…B}, then mask 01 lo=0xC…C → second event data_0=0xC…C, data_1=0xA…A.
- Same-cycle same-address: port0 addr 7 mask 01 lo=1, port1 addr 7 mask 10 hi=2, from reset → t+1 event {data_1=0, data_0=1}, t+2 event {data_1=2, data_0=1}.
- Fill/overflow: both ports effective every cycle with distinct addresses, DEPTH=8 → `io_stall`=1 once free<2. The first drop sets `io_overflow` the next cycle and it stays set. The output sequence equals the accepted events in order with no gaps, and the shadow still reflects the dropped writes.
- Reset mid-stream: 5 entries queued, assert reset for 1 cycle → outputs 0 in the reset cycle and the one after, and no stale event ever appears. A later mask 01 write to a previously written address shows data_1=0.
- Mask 00 with valid=1 → no event, count unchanged, shadow unchanged.
